// File: rtl/oam_dma_bus_arbiter.sv
// Game Boy OAM DMA engine sharing one synchronous memory port with the CPU.
// Each DMA byte takes four slots: DMA read, DMA write, then two CPU slots.
module oam_dma_bus_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          DMA_LENGTH   = 160,
    parameter logic [15:0] HRAM_LO      = 16'hFF80,
    parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataOut,
    input  logic        cpuWriteEnable,
    output logic [7:0]  cpuDataIn,
    output logic        cpuStall,
    output logic [15:0] memAddress,
    output logic [7:0]  memDataOut,
    output logic        memWriteEnable,
    input  logic [7:0]  memDataIn,
    output logic        dmaActive,
    output logic [7:0]  dmaIndex
);

    typedef enum logic [2:0] {
        IDLE,
        S0,
        S1,
        S2,
        S3
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

    state_t     state;
    logic [7:0] src;
    logic [7:0] index;
    logic [7:0] held_data;
    logic       last_cpu_cycle;
    logic       last_blocked;

    logic cpu_slot;
    logic in_hram;
    logic trigger;
    logic blocked;

    always_comb begin
        cpu_slot = (state == IDLE) || (state == S2) || (state == S3);
        in_hram  = (cpuAddress >= HRAM_LO) && (cpuAddress <= HRAM_HI);
        trigger  = cpu_slot && cpuWriteEnable && (cpuAddress == DMA_REG_ADDR);
        blocked  = ((state == S2) || (state == S3)) && !in_hram && !trigger;
    end

    // Memory port mux: the CPU owns the port except in the two DMA slots.
    always_comb begin
        memAddress     = cpuAddress;
        memDataOut     = cpuDataOut;
        memWriteEnable = 1'b0;
        case (state)
            IDLE: memWriteEnable = cpuWriteEnable;
            S0:   memAddress = {src, index};
            S1: begin
                memAddress     = OAM_BASE + {8'h00, index};
                memDataOut     = memDataIn;
                memWriteEnable = 1'b1;
            end
            S2, S3: memWriteEnable = cpuWriteEnable && !blocked;
            default: memWriteEnable = 1'b0;
        endcase
        // Kill the strobe while reset is held so an aborted transfer cannot commit a byte.
        if (reset) begin
            memWriteEnable = 1'b0;
        end
    end

    always_comb begin
        cpuStall  = (state == S0) || (state == S1);
        dmaActive = (state != IDLE);
        dmaIndex  = index;
        if (last_cpu_cycle) begin
            cpuDataIn = last_blocked ? 8'hFF : memDataIn;
        end else begin
            cpuDataIn = held_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            src            <= 8'h00;
            index          <= 8'h00;
            held_data      <= 8'hFF;
            last_cpu_cycle <= 1'b1;
            last_blocked   <= 1'b0;
        end else begin
            last_cpu_cycle <= cpu_slot;
            last_blocked   <= blocked;
            if (last_cpu_cycle) begin
                held_data <= cpuDataIn;
            end
            // A trigger wins over every slot transition, including end of transfer.
            if (trigger) begin
                src   <= cpuDataOut;
                index <= 8'h00;
                state <= S0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    S0:   state <= S1;
                    S1:   state <= S2;
                    S2:   state <= S3;
                    S3: begin
                        if (index == LAST_INDEX) begin
                            state <= IDLE;
                        end else begin
                            index <= index + 8'd1;
                            state <= S0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// Bench for oam_dma_bus_arbiter: memory models plus a byte-level reference image
// predicting DMA copies, CPU arbitration and read returns.
module tb_oam_dma_bus_arbiter;

    localparam logic [15:0] DMA_REG = 16'hFF46;
    localparam logic [15:0] OAM     = 16'hFE00;
    localparam int          LEN     = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDataOut;
    logic        cpuWriteEnable;
    logic [7:0]  cpuDataIn;
    logic        cpuStall;
    logic [15:0] memAddress;
    logic [7:0]  memDataOut;
    logic        memWriteEnable;
    logic [7:0]  memDataIn;
    logic        dmaActive;
    logic [7:0]  dmaIndex;

    logic [15:0] addr1;
    logic [7:0]  wdata1;
    logic        we1;
    logic [7:0]  rdata1;
    logic        stall1;
    logic [15:0] maddr1;
    logic [7:0]  mwdata1;
    logic        mwe1;
    logic [7:0]  mrdata1;
    logic        active1;
    logic [7:0]  index1;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] mem1    [0:65535];

    int checks = 0;
    int errors = 0;

    oam_dma_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpuAddress(cpuAddress), .cpuDataOut(cpuDataOut), .cpuWriteEnable(cpuWriteEnable),
        .cpuDataIn(cpuDataIn), .cpuStall(cpuStall),
        .memAddress(memAddress), .memDataOut(memDataOut), .memWriteEnable(memWriteEnable),
        .memDataIn(memDataIn), .dmaActive(dmaActive), .dmaIndex(dmaIndex)
    );

    oam_dma_bus_arbiter #(.DMA_LENGTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpuAddress(addr1), .cpuDataOut(wdata1), .cpuWriteEnable(we1),
        .cpuDataIn(rdata1), .cpuStall(stall1),
        .memAddress(maddr1), .memDataOut(mwdata1), .memWriteEnable(mwe1),
        .memDataIn(mrdata1), .dmaActive(active1), .dmaIndex(index1)
    );

    always @(posedge clk) begin
        if (memWriteEnable) mem[memAddress] <= memDataOut;
        memDataIn <= mem[memAddress];
    end

    always @(posedge clk) begin
        if (mwe1) mem1[maddr1] <= mwdata1;
        mrdata1 <= mem1[maddr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpuWriteEnable = we;
        cpuAddress     = a;
        cpuDataOut     = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_hram(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    task automatic compare_image(input string tag);
        int diffs = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk(tag, 32'(diffs), 32'd0);
    endtask

    task automatic fill_page(input logic [7:0] page);
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[{page, 8'(i)}]     = v;
            ref_mem[{page, 8'(i)}] = v;
        end
    endtask

    task automatic rand_access(output logic we, output logic [15:0] a, output logic [7:0] d);
        we = 1'($urandom_range(0, 1));
        d  = 8'($urandom);
        if ($urandom_range(0, 1) == 1) a = 16'(16'hFF80 + $urandom_range(0, 126));
        else                           a = 16'(16'hC000 + $urandom_range(0, 8191));
    endtask

    // Access the CPU presents for the coming CPU slot (held through the stalled slots).
    task automatic pick(input int mode, input int b, input int slot, input bit restarted,
                        output logic we, output logic [15:0] a, output logic [7:0] d);
        we = 1'b0; a = 16'h0000; d = 8'h00;
        case (mode)
            1: begin
                if (slot == 0 && b == 0)      a = 16'hFF80;
                else if (slot == 0 && b == 1) a = 16'hC000;
                else if (slot == 0 && b == 2) begin we = 1'b1; a = 16'hC123; d = 8'h77; end
                else rand_access(we, a, d);
            end
            2: if (slot == 0 && b == 50 && !restarted) begin we = 1'b1; a = DMA_REG; d = 8'hD0; end
            3: rand_access(we, a, d);
            default: ;
        endcase
    endtask

    task automatic run_dma(input logic [7:0] src, input int mode, output logic [7:0] final_src);
        int k, slot, b;
        logic [7:0] cur, expd, d;
        logic [15:0] a;
        logic we;
        bit have, restarted;
        drive(1'b1, DMA_REG, src);
        @(negedge clk);
        chk("trig_fwd_we", 32'(memWriteEnable), 32'd1);
        chk("trig_fwd_addr", 32'(memAddress), 32'(DMA_REG));
        chk("trig_stall", 32'(cpuStall), 32'd0);
        ref_mem[DMA_REG] = src;
        step;
        cur = src; k = 0; have = 0; restarted = 0; we = 0; a = 0; d = 0; expd = 0;
        while (k < 4 * LEN) begin
            slot = k % 4;
            b    = k / 4;
            if (slot == 0 || slot == 3) begin
                pick(mode, b, slot, restarted, we, a, d);
                drive(we, a, d);
            end
            @(negedge clk);
            chk("dma_active", 32'(dmaActive), 32'd1);
            chk("stall", 32'(cpuStall), (slot < 2) ? 32'd1 : 32'd0);
            chk("index", 32'(dmaIndex), 32'(b));
            if (have) chk("cpu_rdata", 32'(cpuDataIn), 32'(expd));
            if (slot == 0) begin
                chk("s0_no_write", 32'(memWriteEnable), 32'd0);
                chk("s0_addr", 32'(memAddress), 32'({cur, b[7:0]}));
            end
            if (slot == 1) begin
                chk("s1_write", 32'(memWriteEnable), 32'd1);
                chk("s1_addr", 32'(memAddress), 32'(OAM + 16'(b)));
                chk("s1_data", 32'(memDataOut), 32'(ref_mem[{cur, b[7:0]}]));
            end
            k++;
            if (slot >= 2) begin
                if (we && a == DMA_REG) begin
                    ref_mem[a] = d; cur = d; k = 0; have = 0; restarted = 1;
                end else if (is_hram(a)) begin
                    if (we) begin ref_mem[a] = d; have = 0; end
                    else begin have = 1; expd = ref_mem[a]; end
                end else begin
                    have = !we;
                    expd = 8'hFF;
                end
            end
            step;
        end
        drive(1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("dma_done", 32'(dmaActive), 32'd0);
        chk("idle_stall", 32'(cpuStall), 32'd0);
        if (have) chk("last_rdata", 32'(cpuDataIn), 32'(expd));
        for (int i = 0; i < LEN; i++) ref_mem[OAM + 16'(i)] = ref_mem[{cur, 8'(i)}];
        final_src = cur;
        step;
    endtask

    initial begin
        logic [7:0] fsrc, page, v, old_c123;
        int diffs, act_cnt, wr_cnt, oam_wr;

        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00; ref_mem[i] = 8'h00; mem1[i] = 8'h00;
        end
        addr1 = 16'h0000; wdata1 = 8'h00; we1 = 1'b0;
        reset = 1'b1;
        drive(1'b1, 16'hC010, 8'h5A);
        #12;
        chk("rst_active", 32'(dmaActive), 32'd0);
        chk("rst_stall", 32'(cpuStall), 32'd0);
        chk("rst_index", 32'(dmaIndex), 32'd0);
        chk("rst_mwe", 32'(memWriteEnable), 32'd0);
        step;
        @(negedge clk);
        reset = 1'b0;
        step;

        // Idle pass-through
        drive(1'b1, 16'hC010, 8'h5A);
        @(negedge clk);
        chk("pt_wr_we", 32'(memWriteEnable), 32'd1);
        chk("pt_wr_addr", 32'(memAddress), 32'hC010);
        chk("pt_wr_data", 32'(memDataOut), 32'h5A);
        chk("pt_wr_stall", 32'(cpuStall), 32'd0);
        ref_mem[16'hC010] = 8'h5A;
        step;
        drive(1'b0, 16'hC010, 8'h00);
        @(negedge clk);
        chk("pt_rd_we", 32'(memWriteEnable), 32'd0);
        chk("pt_rd_stall", 32'(cpuStall), 32'd0);
        step;
        drive(1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("pt_rd_data", 32'(cpuDataIn), 32'h5A);
        step;

        // Full DMA from C0 with i^A5 pattern
        for (int i = 0; i < LEN; i++) begin
            mem[16'hC000 + 16'(i)]     = 8'(i) ^ 8'hA5;
            ref_mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'hA5;
        end
        mem[16'hFF80] = 8'h3C; ref_mem[16'hFF80] = 8'h3C;
        run_dma(8'hC0, 0, fsrc);
        chk("ff46_value", 32'(mem[DMA_REG]), 32'hC0);
        chk("oam_first", 32'(mem[OAM]), 32'hA5);
        chk("oam_last", 32'(mem[OAM + 16'(LEN - 1)]), 32'((LEN - 1) ^ 8'hA5));
        compare_image("image_full");

        // Arbitration during DMA with random CPU traffic
        page = 8'($urandom_range(8'hC1, 8'hCF));
        fill_page(page);
        old_c123 = mem[16'hC123];
        run_dma(page, 1, fsrc);
        chk("c123_unchanged", 32'(mem[16'hC123]), 32'(old_c123));
        compare_image("image_arb");

        // Restart mid-transfer from D0
        fill_page(8'hD0);
        run_dma(8'hC0, 2, fsrc);
        chk("restart_src", 32'(fsrc), 32'hD0);
        diffs = 0;
        for (int i = 0; i < LEN; i++) if (mem[OAM + 16'(i)] !== mem[16'hD000 + 16'(i)]) diffs++;
        chk("restart_oam", 32'(diffs), 32'd0);
        compare_image("image_restart");

        // Fully random transfer
        page = 8'($urandom_range(8'hC1, 8'hDF));
        fill_page(page);
        run_dma(page, 3, fsrc);
        compare_image("image_random");

        // Reset during byte 20 DMA write slot
        fill_page(8'hE2);
        for (int i = 0; i < LEN; i++) begin
            mem[OAM + 16'(i)] = 8'hAA; ref_mem[OAM + 16'(i)] = 8'hAA;
        end
        drive(1'b1, DMA_REG, 8'hE2);
        ref_mem[DMA_REG] = 8'hE2;
        step;
        drive(1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 81; i++) step;
        reset = 1'b1;
        #1;
        chk("rst_mid_active", 32'(dmaActive), 32'd0);
        chk("rst_mid_mwe", 32'(memWriteEnable), 32'd0);
        for (int i = 0; i < 20; i++) ref_mem[OAM + 16'(i)] = ref_mem[{8'hE2, 8'(i)}];
        step;
        step;
        @(negedge clk);
        reset = 1'b0;
        step;
        v = 8'($urandom);
        drive(1'b1, 16'hC020, v);
        @(negedge clk);
        chk("post_rst_we", 32'(memWriteEnable), 32'd1);
        chk("post_rst_addr", 32'(memAddress), 32'hC020);
        ref_mem[16'hC020] = v;
        step;
        drive(1'b0, 16'hC020, 8'h00);
        step;
        drive(1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        chk("post_rst_rdata", 32'(cpuDataIn), 32'(v));
        chk("fe14_kept", 32'(mem[16'hFE14]), 32'hAA);
        chk("fe13_copied", 32'(mem[16'hFE13]), 32'(ref_mem[16'hE213]));
        step;
        compare_image("image_reset");

        // Single-byte transfer on the DMA_LENGTH=1 instance
        v = 8'($urandom_range(1, 255));
        mem1[16'hE100] = v; mem1[16'hFE00] = 8'h00; mem1[16'hFE01] = 8'h00;
        we1 = 1'b1; addr1 = DMA_REG; wdata1 = 8'hE1;
        step;
        we1 = 1'b0; addr1 = 16'h0000; wdata1 = 8'h00;
        act_cnt = 0; wr_cnt = 0; oam_wr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (active1) act_cnt++;
            if (mwe1) begin
                wr_cnt++;
                if (maddr1 == 16'hFE00) oam_wr++;
            end
            if (i < 4) chk("len1_stall", 32'(stall1), (i < 2) ? 32'd1 : 32'd0);
            step;
        end
        chk("len1_active_cycles", 32'(act_cnt), 32'd4);
        chk("len1_writes", 32'(wr_cnt), 32'd1);
        chk("len1_fe00_writes", 32'(oam_wr), 32'd1);
        chk("len1_fe00", 32'(mem1[16'hFE00]), 32'(v));
        chk("len1_fe01", 32'(mem1[16'hFE01]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
